// File: rtl/sram_bist_pkg.sv
// Shared types, mode encodings and pattern generator for the SRAM BIST controller.
package sram_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] MODE_SQUARE  = 2'd0;
   localparam logic [1:0] MODE_INDEX   = 2'd1;
   localparam logic [1:0] MODE_CHECKER = 2'd2;
   localparam logic [1:0] MODE_INVERT  = 2'd3;

   localparam logic [63:0] CHK_EVEN = {8{8'h55}};
   localparam logic [63:0] CHK_ODD  = {8{8'hAA}};

   // Index-derived values are confined to aw bits (2*aw for the square); callers cut to DW.
   function automatic logic [63:0] pat(input logic [31:0] i, input logic [1:0] mode, input int aw);
      logic [63:0] iw;
      logic [63:0] amask;
      logic [63:0] sq;
      amask = (64'd1 << aw) - 64'd1;
      iw    = {32'd0, i} & amask;
      sq    = iw * iw;
      if (2 * aw < 64) begin
         sq = sq & ((64'd1 << (2 * aw)) - 64'd1);
      end
      case (mode)
         MODE_INDEX:   pat = iw;
         MODE_CHECKER: pat = i[0] ? CHK_ODD : CHK_EVEN;
         MODE_INVERT:  pat = ~iw & amask;
         default:      pat = sq;
      endcase
   endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Expected-data pipeline, read-data comparator and mismatch counter.
// SRAM_BIST_FAILLOG_EN adds a capture of the first mismatch (address, expected, received).
module sram_bist_cmp
   import sram_bist_pkg::*;
#(
   parameter int AW     = 6,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push_valid,
   input  logic [DW-1:0] push_data,
   input  logic [DW-1:0] mem_q,
   output logic [AW:0]   err_cnt
`ifdef SRAM_BIST_FAILLOG_EN
   ,
   input  logic [AW-1:0] push_addr,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_exp,
   output logic [DW-1:0] fail_got
`endif
);

`ifdef SRAM_BIST_FAILLOG_EN
   localparam int W = 1 + AW + DW;
`else
   localparam int W = 1 + DW;
`endif
   localparam int PW = RD_LAT * W;
   localparam logic [AW:0] ERR_ONE = 1;

   logic [PW-1:0] pipe;
   logic [W-1:0]  entry;
   logic [W-1:0]  out_entry;
   logic          out_vld;
   logic [DW-1:0] out_exp;
   logic          mismatch;

`ifdef SRAM_BIST_FAILLOG_EN
   assign entry = {push_valid, push_addr, push_data};
`else
   assign entry = {push_valid, push_data};
`endif

   // Oldest entry sits at the top of the shift vector and lines up with mem_q.
   assign out_entry = pipe[PW-1 -: W];
   assign out_vld   = out_entry[W-1];
   assign out_exp   = out_entry[DW-1:0];
   assign mismatch  = out_vld && (out_exp != mem_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe    <= '0;
         err_cnt <= '0;
      end else begin
         pipe <= (pipe << W) | PW'(entry);
         if (clear) begin
            err_cnt <= '0;
         end else if (mismatch) begin
            err_cnt <= err_cnt + ERR_ONE;
         end
      end
   end

`ifdef SRAM_BIST_FAILLOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_got  <= '0;
      end else if (clear) begin
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_got  <= '0;
      end else if (mismatch && (err_cnt == '0)) begin
         fail_addr <= out_entry[W-2 -: AW];
         fail_exp  <= out_exp;
         fail_got  <= mem_q;
      end
   end
`endif

endmodule

// File: rtl/sram_bist_ctrl.sv
// Single-port SRAM BIST controller with idle host bypass.
// SRAM_BIST_FAILLOG_EN exposes fail_addr/fail_exp/fail_got for the first mismatch.
module sram_bist_ctrl
   import sram_bist_pkg::*;
#(
   parameter int AW     = 6,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_cnt,
   input  logic [AW-1:0] host_a,
   input  logic [DW-1:0] host_d,
   input  logic          host_cen,
   input  logic          host_wen,
   output logic [DW-1:0] host_q,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d,
   output logic          mem_cen,
   output logic          mem_wen,
   input  logic [DW-1:0] mem_q
`ifdef SRAM_BIST_FAILLOG_EN
   ,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_exp,
   output logic [DW-1:0] fail_got
`endif
);

   localparam logic [AW-1:0] CNT_LAST   = '1;
   localparam logic [AW-1:0] CNT_ONE    = 1;
   localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] cnt;
   logic [1:0]    drain_cnt;
   logic [1:0]    mode_r;
   logic          pass_r;
   logic [DW-1:0] pat_data;
   logic          clear;

   assign pat_data = DW'(pat(32'(cnt), mode_r, AW));
   assign clear    = (state == ST_IDLE) && start;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);
   assign pass     = done ? (err_cnt == '0) : pass_r;
   assign host_q   = mem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mem_a      = host_a;
      mem_d      = host_d;
      mem_cen    = host_cen;
      mem_wen    = host_wen;
      unique case (state)
         ST_IDLE: begin
            if (start) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            mem_a   = cnt;
            mem_d   = pat_data;
            mem_cen = 1'b0;
            mem_wen = 1'b0;
            if (cnt == CNT_LAST) state_next = ST_READ;
         end
         ST_READ: begin
            mem_a   = cnt;
            mem_d   = '0;
            mem_cen = 1'b0;
            mem_wen = 1'b1;
            if (cnt == CNT_LAST) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            mem_a   = '0;
            mem_d   = '0;
            mem_cen = 1'b1;
            mem_wen = 1'b1;
            if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
         end
         default: begin
            mem_a      = '0;
            mem_d      = '0;
            mem_cen    = 1'b1;
            mem_wen    = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   // The address counter wraps naturally from N-1 to 0 between the write and read sweeps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         drain_cnt <= '0;
         mode_r    <= MODE_SQUARE;
         pass_r    <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_r <= mode;
                  cnt    <= '0;
                  pass_r <= 1'b0;
               end
            end
            ST_WRITE: cnt <= cnt + CNT_ONE;
            ST_READ: begin
               cnt       <= cnt + CNT_ONE;
               drain_cnt <= '0;
            end
            ST_DRAIN: drain_cnt <= drain_cnt + 2'd1;
            default:  pass_r <= (err_cnt == '0);
         endcase
      end
   end

   sram_bist_cmp #(
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_cmp (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .push_valid (state == ST_READ),
      .push_data  (pat_data),
      .mem_q      (mem_q),
      .err_cnt    (err_cnt)
`ifdef SRAM_BIST_FAILLOG_EN
      ,
      .push_addr  (cnt),
      .fail_addr  (fail_addr),
      .fail_exp   (fail_exp),
      .fail_got   (fail_got)
`endif
   );

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: one instance at RD_LAT=1 and one at RD_LAT=3, each with a behavioural SRAM.
// Honours SRAM_BIST_FAILLOG_EN for the first-mismatch outputs.
module tb_sram_bist_ctrl;

   localparam int AW = 6;
   localparam int DW = 8;
   localparam int N  = 64;

   logic clk = 1'b0;
   logic rst;
   logic start1, start3;
   logic [1:0] mode;
   logic [AW-1:0] host_a;
   logic [DW-1:0] host_d;
   logic host_cen, host_wen;

   logic busy1, done1, pass1, mem_cen1, mem_wen1;
   logic [AW:0] err1;
   logic [DW-1:0] host_q1, mem_d1, mem_q1;
   logic [AW-1:0] mem_a1;
   logic busy3, done3, pass3, mem_cen3, mem_wen3;
   logic [AW:0] err3;
   logic [DW-1:0] host_q3, mem_d3, mem_q3;
   logic [AW-1:0] mem_a3;
`ifdef SRAM_BIST_FAILLOG_EN
   logic [AW-1:0] fa1, fa3;
   logic [DW-1:0] fe1, fg1, fe3, fg3;
`endif

   bit f4_1, f7_1, f4_3;
   logic [DW-1:0] mem1 [N];
   logic [DW-1:0] mem3 [N];
   logic [DW-1:0] q3p [3];

   typedef struct {
      int err;
      int pass_v;
   } exp_t;
   exp_t sbq[$];
   logic [DW-1:0] rdq[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .host_a(host_a), .host_d(host_d), .host_cen(host_cen), .host_wen(host_wen),
      .host_q(host_q1), .mem_a(mem_a1), .mem_d(mem_d1), .mem_cen(mem_cen1),
      .mem_wen(mem_wen1), .mem_q(mem_q1)
`ifdef SRAM_BIST_FAILLOG_EN
      , .fail_addr(fa1), .fail_exp(fe1), .fail_got(fg1)
`endif
   );

   sram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .mode(mode),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
      .host_a(host_a), .host_d(host_d), .host_cen(host_cen), .host_wen(host_wen),
      .host_q(host_q3), .mem_a(mem_a3), .mem_d(mem_d3), .mem_cen(mem_cen3),
      .mem_wen(mem_wen3), .mem_q(mem_q3)
`ifdef SRAM_BIST_FAILLOG_EN
      , .fail_addr(fa3), .fail_exp(fe3), .fail_got(fg3)
`endif
   );

   function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [AW-1:0] a,
                                            input bit f4, input bit f7);
      logic [DW-1:0] r;
      r = v;
      if (f4 && a == 6'd4) r[0] = 1'b1;
      if (f7) r[7] = 1'b0;
      return r;
   endfunction

   // Faults act on the read path only, so the stored image stays what the controller wrote.
   always @(posedge clk) begin
      if (!mem_cen1 && !mem_wen1) mem1[mem_a1] <= mem_d1;
      if (!mem_cen1 && mem_wen1) mem_q1 <= faulty(mem1[mem_a1], mem_a1, f4_1, f7_1);
   end

   always @(posedge clk) begin
      if (!mem_cen3 && !mem_wen3) mem3[mem_a3] <= mem_d3;
      if (!mem_cen3 && mem_wen3) q3p[0] <= faulty(mem3[mem_a3], mem_a3, f4_3, 1'b0);
      q3p[1] <= q3p[0];
      q3p[2] <= q3p[1];
   end
   assign mem_q3 = q3p[2];

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_bist(input bit use3, input logic [1:0] m, input int exp_err,
                           input int exp_cycle, input int poke);
      exp_t e;
      int k;
      e.err = exp_err;
      e.pass_v = (exp_err == 0) ? 1 : 0;
      sbq.push_back(e);
      @(negedge clk);
      mode = m;
      if (use3) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      k = 1;
      check_output("busy_start", use3 ? busy3 : busy1, 1);
      check_output("first_write_wen", use3 ? mem_wen3 : mem_wen1, 0);
      while (!(use3 ? done3 : done1) && k < 400) begin
         if (k == poke) begin
            mode = 2'd0;
            if (use3) start3 = 1'b1; else start1 = 1'b1;
         end
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         k++;
      end
      check_output("done_cycle", k, exp_cycle);
      e = sbq.pop_front();
      check_output("err_cnt", use3 ? err3 : err1, e.err);
      check_output("pass", use3 ? pass3 : pass1, e.pass_v);
      @(negedge clk);
      check_output("done_pulse_end", use3 ? done3 : done1, 0);
      check_output("busy_end", use3 ? busy3 : busy1, 0);
      check_output("pass_hold", use3 ? pass3 : pass1, e.pass_v);
   endtask

   initial begin
      rst = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      mode = 2'd0;
      host_a = 6'd5;
      host_d = 8'hA5;
      host_cen = 1'b1;
      host_wen = 1'b1;
      repeat (3) @(negedge clk);
      check_output("rst_busy", busy1, 0);
      check_output("rst_done", done1, 0);
      check_output("rst_pass", pass1, 0);
      check_output("rst_err", err1, 0);
      check_output("rst_mem_cen", mem_cen1, 1);
      check_output("rst_mem_a", mem_a1, 5);
      rst = 1'b0;
      @(negedge clk);
      check_output("idle_busy", busy1, 0);
      check_output("idle_mem_d", mem_d1, 8'hA5);

      $display("[TB] mode 0, ideal memory");
      run_bist(1'b0, 2'd0, 0, 2 * N + 2, -1);
      check_output("word10", mem1[10], 8'h64);
      check_output("word63", mem1[63], 8'h81);

      $display("[TB] mode 0, bit0 forced on address 4");
      f4_1 = 1'b1;
      run_bist(1'b0, 2'd0, 1, 2 * N + 2, -1);
      f4_1 = 1'b0;
`ifdef SRAM_BIST_FAILLOG_EN
      check_output("fail_addr", fa1, 4);
      check_output("fail_exp", fe1, 8'h10);
      check_output("fail_got", fg1, 8'h11);
`endif

      $display("[TB] mode 2, bit7 stuck at 0 on reads");
      f7_1 = 1'b1;
      run_bist(1'b0, 2'd2, 32, 2 * N + 2, -1);
      check_output("chk_word0", mem1[0], 8'h55);
      check_output("chk_word1", mem1[1], 8'hAA);

      $display("[TB] reset during read at i=20");
      @(negedge clk);
      mode = 2'd2;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (84) @(negedge clk);
      check_output("mid_read_addr", mem_a1, 20);
      check_output("mid_err_nonzero", (err1 != 0) ? 1 : 0, 1);
      rst = 1'b1;
      #1;
      check_output("abort_busy", busy1, 0);
      check_output("abort_mem_cen", mem_cen1, 1);
      check_output("abort_err", err1, 0);
      @(negedge clk);
      check_output("abort_done", done1, 0);
      rst = 1'b0;
      f7_1 = 1'b0;
      run_bist(1'b0, 2'd0, 0, 2 * N + 2, -1);

      $display("[TB] idle bypass");
      @(negedge clk);
      host_a = 6'd7;
      host_d = 8'h3C;
      host_cen = 1'b0;
      host_wen = 1'b0;
      #1;
      check_output("bypass_wen", mem_wen1, 0);
      check_output("bypass_d", mem_d1, 8'h3C);
      @(negedge clk);
      host_wen = 1'b1;
      host_d = 8'h00;
      rdq.push_back(8'h3C);
      @(negedge clk);
      host_cen = 1'b1;
      check_output("bypass_host_q", host_q1, rdq.pop_front());

      $display("[TB] start pulsed while busy");
      run_bist(1'b0, 2'd1, 0, 2 * N + 2, 70);
      check_output("mode_latched_word10", mem1[10], 8'h0A);

      $display("[TB] RD_LAT=3");
      run_bist(1'b1, 2'd0, 0, 2 * N + 4, -1);
      f4_3 = 1'b1;
      run_bist(1'b1, 2'd0, 1, 2 * N + 4, -1);
      f4_3 = 1'b0;
`ifdef SRAM_BIST_FAILLOG_EN
      check_output("lat3_fail_addr", fa3, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
